mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side endpoint of the request/response memory interface: accepts requests (valid/addr/rw/byteen/data/tag/ready) and services them from an internal byte-enabled RAM.
- Returns read responses (data/tag) in order after a fixed pipeline latency.
- A bounded response queue absorbs response backpressure.
- Used as the terminating slave behind the width adapters in AFU-level integration and in unit benches.

Parameters:
- DATA_WIDTH, 512, width of one memory word in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width; RAM depth is 2**ADDR_WIDTH words.
- TAG_WIDTH, 8, request/response tag width.
- LATENCY, 2, cycles from read acceptance to earliest rsp_valid; must be >= 1.
- RSP_QUEUE_SIZE, 4, maximum reads in flight plus queued; must be >= LATENCY.
- DATA_SIZE, DATA_WIDTH/8, byte-enable width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_req_valid  in  1  request valid
- mem_req_addr  in  ADDR_WIDTH  word address
- mem_req_rw  in  1  1=write, 0=read
- mem_req_byteen  in  DATA_SIZE  write byte enables
- mem_req_data  in  DATA_WIDTH  write data
- mem_req_tag  in  TAG_WIDTH  request tag
- mem_req_ready  out  1  request accepted when valid&ready at posedge
- mem_rsp_valid  out  1  read response valid
- mem_rsp_data  out  DATA_WIDTH  read data
- mem_rsp_tag  out  TAG_WIDTH  tag of the originating read
- mem_rsp_ready  in  1  consumer accepts response

Behaviour:
- Reset: reset and clock are as already decided — synchronous, active-high reset named reset, clock named clk.
- Values during and after reset:
  - mem_rsp_valid=0.
  - mem_req_ready=0 while reset is high; it rises in the first cycle after reset deasserts.
  - pending=0; pipeline valid bits and queue cleared.
  - RAM contents are not reset.
- Request acceptance:
  - mem_req_ready = !reset && (pending < RSP_QUEUE_SIZE). This applies to both reads and writes, so ordering is kept simple.
  - mem_req_ready must not depend combinationally on mem_req_valid.
  - pending is the number of accepted reads not yet returned (in pipeline plus in queue). Width is clog2(RSP_QUEUE_SIZE+1).
- Write (rw=1) accepted:
  - At that edge, byte i of RAM[addr] takes mem_req_data[8i+7:8i] for each byteen[i]=1; other bytes are unchanged.
  - No response is generated. pending is unchanged.
- Read (rw=0) accepted:
  - RAM[addr] is sampled at the accept edge, so it reflects every write accepted in earlier cycles.
  - {data, tag} enters a LATENCY-1 stage valid-tagged pipeline, then is written into the response FIFO (depth RSP_QUEUE_SIZE).
  - The pipeline never stalls. The credit check guarantees FIFO space.
- Latency: a read accepted in cycle t produces mem_rsp_valid in cycle t+LATENCY when the queue is empty. Back-to-back reads sustain 1 response per cycle.
- Response output:
  - mem_rsp_valid = FIFO not empty; mem_rsp_data/mem_rsp_tag are the FIFO head, registered (no combinational path from request inputs).
  - Head is popped on mem_rsp_valid && mem_rsp_ready.
  - While valid and not ready, head data/tag hold stable.
- pending update:
  - +1 on read accept; -1 on response fire.
  - Read accept and response fire in the same cycle: pending is unchanged.
  - Never exceeds RSP_QUEUE_SIZE; never underflows (assertion).
- Full: pending==RSP_QUEUE_SIZE deasserts mem_req_ready for all requests, including writes. A response fire in cycle c re-enables ready in cycle c+1.
- Ordering: responses leave strictly in read acceptance order. Tags are returned verbatim and never interpreted.
- Reset mid-operation: all in-flight and queued responses are discarded without being presented. mem_rsp_valid=0 in the cycle after the reset edge. RAM writes already accepted persist.
- Assertions (simulation only):
  - No response fire while mem_rsp_valid=0.
  - pending <= RSP_QUEUE_SIZE.
  - LATENCY >= 1 and RSP_QUEUE_SIZE >= LATENCY (static).

Test Plan:
- Write then read: write addr 0x05, data 0xA5 repeated, byteen all ones, tag 0x11; then read addr 0x05, tag 0x22 → exactly one response, tag 0x22, data 0xA5 repeated, valid exactly LATENCY cycles after the read accept.
- Partial byteen: RAM[3]=0 via full write; write 0xFF repeated with byteen=0x...0001; read addr 3 → data byte0=0xFF, all other bytes 0x00.
- Backpressure fill: mem_rsp_ready=0, issue 6 reads tags 1..6 with RSP_QUEUE_SIZE=4 → tags 1..4 accepted, ready low after the 4th. Then raise rsp_ready → responses 1,2,3,4 in order; ready reasserts one cycle after the first pop; tags 5,6 are then accepted and returned.
- Simultaneous events: with pending=4, fire a response and hold a read valid → read accepted the following cycle; pending stays 4 across that cycle; no tag lost or duplicated.
- Throughput: 16 back-to-back reads tags 0..15 with rsp_ready=1 → 16 consecutive response cycles, tags 0..15 in order, first at t+LATENCY.
- Reset mid-flight: 3 reads outstanding, assert reset 1 cycle → no responses afterwards, mem_rsp_valid=0, ready=1 after reset. A subsequent read returns data written before the reset.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side request/response endpoint: byte-enabled RAM, fixed-latency read
// pipeline and a credit-protected in-order response queue.
module mem_responder #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 8,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4,
  parameter int DATA_SIZE      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req_valid,
  input  logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_rw,
  input  logic [DATA_SIZE-1:0]  mem_req_byteen,
  input  logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]  mem_req_tag,
  output logic                  mem_req_ready,
  output logic                  mem_rsp_valid,
  output logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]  mem_rsp_tag,
  input  logic                  mem_rsp_ready
);

  localparam int CNT_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int ENT_W = TAG_WIDTH + DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit PARAMS_OK = (LATENCY >= 1) && (RSP_QUEUE_SIZE >= LATENCY) &&
                             (DATA_WIDTH % 8 == 0);

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic [CNT_W-1:0]      pending_q, pending_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [ENT_W-1:0]      fifo_q [RSP_QUEUE_SIZE];
  logic [ENT_W-1:0]      fifo_d [RSP_QUEUE_SIZE];
  logic [CNT_W-1:0]      wr_idx;
  logic                  rd_acc, wr_acc, rsp_fire, push_vld;
  logic [ENT_W-1:0]      rd_ent, push_ent;

  // Credit check covers writes too, so a full queue stalls all traffic.
  assign mem_req_ready = !reset && (pending_q < CNT_W'(RSP_QUEUE_SIZE));
  assign rd_acc        = mem_req_valid && mem_req_ready && !mem_req_rw;
  assign wr_acc        = mem_req_valid && mem_req_ready && mem_req_rw;
  assign rd_ent        = {mem_req_tag, ram_q[mem_req_addr]};

  assign mem_rsp_valid = !reset && (fifo_cnt_q != '0);
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign {mem_rsp_tag, mem_rsp_data} = fifo_q[0];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (mem_req_byteen[i]) ram_q[mem_req_addr][8*i +: 8] <= mem_req_data[8*i +: 8];
      end
    end
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int STAGES = LATENCY - 1;
      logic [STAGES-1:0] pipe_vld_q, pipe_vld_d;
      logic [ENT_W-1:0]  pipe_ent_q [STAGES];
      logic [ENT_W-1:0]  pipe_ent_d [STAGES];

      always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_ent_d    = pipe_ent_q;
        pipe_vld_d[0] = rd_acc;
        pipe_ent_d[0] = rd_ent;
        for (int i = 1; i < STAGES; i++) begin
          pipe_vld_d[i] = pipe_vld_q[i-1];
          pipe_ent_d[i] = pipe_ent_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) pipe_vld_q <= '0;
        else       pipe_vld_q <= pipe_vld_d;
        pipe_ent_q <= pipe_ent_d;
      end

      assign push_vld = pipe_vld_q[STAGES-1];
      assign push_ent = pipe_ent_q[STAGES-1];
    end else begin : g_nopipe
      assign push_vld = rd_acc;
      assign push_ent = rd_ent;
    end
  endgenerate

  // Shift-register queue keeps the head in a fixed flop; push never overflows
  // because pending already bounds pipeline plus queue occupancy.
  always_comb begin
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_idx     = fifo_cnt_q;
    if (rsp_fire) begin
      for (int i = 0; i < RSP_QUEUE_SIZE - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      wr_idx     = fifo_cnt_q - CNT_W'(1);
    end
    if (push_vld) begin
      for (int i = 0; i < RSP_QUEUE_SIZE; i++) begin
        if (CNT_W'(i) == wr_idx) fifo_d[i] = push_ent;
      end
      fifo_cnt_d = fifo_cnt_d + CNT_W'(1);
    end
  end

  always_comb begin
    pending_d = pending_q + CNT_W'(rd_acc) - CNT_W'(rsp_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    assert (PARAMS_OK);
    if (!reset) begin
      assert (!(rsp_fire && pending_q == '0));
      assert (pending_q <= CNT_W'(RSP_QUEUE_SIZE));
      assert (fifo_cnt_q <= pending_q);
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: write/read, partial byte enables,
// backpressure, credit re-enable, throughput and mid-flight reset.
module tb_mem_responder;
  localparam int DW = 512;
  localparam int AW = 8;
  localparam int TW = 8;
  localparam int L  = 2;
  localparam int Q  = 4;
  localparam int DS = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_rw;
  logic [DS-1:0] mem_req_byteen;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;

  int checks = 0;
  int passed = 0;

  mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .LATENCY(L), .RSP_QUEUE_SIZE(Q), .DATA_SIZE(DS)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    logic [7:0] b;
    b = a ^ 8'h5A;
    return {DS{b}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic chk_rsp(input string name, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    check({name, "_valid"}, DW'(mem_rsp_valid), DW'(1'b1));
    check({name, "_tag"}, DW'(mem_rsp_tag), DW'(tag));
    check({name, "_data"}, mem_rsp_data, data);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DS-1:0] be);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = a;
    mem_req_data   = d;
    mem_req_byteen = be;
    mem_req_tag    = 8'h11;
    check("wr_ready", DW'(mem_req_ready), DW'(1'b1));
    @(negedge clk);
    mem_req_valid  = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b0;
    mem_req_addr   = a;
    mem_req_tag    = t;
    mem_req_byteen = '0;
    mem_req_data   = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
    set_rd(a, t);
    check("rd_ready", DW'(mem_req_ready), DW'(1'b1));
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0;
    mem_req_byteen = '0; mem_req_data = '0; mem_req_tag = '0;
    mem_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", DW'(mem_req_ready), DW'(1'b0));
    check("rst_rsp_valid", DW'(mem_rsp_valid), DW'(1'b0));
    reset = 1'b0;
    #1;
    check("ready_after_rst", DW'(mem_req_ready), DW'(1'b1));
    @(negedge clk);
    check("rsp_valid_after_rst", DW'(mem_rsp_valid), DW'(1'b0));

    // Write then read, exact latency and single response
    wr(8'h05, {DS{8'hA5}}, '1);
    check("wr_no_rsp", DW'(mem_rsp_valid), DW'(1'b0));
    mem_rsp_ready = 1'b1;
    rd(8'h05, 8'h22);
    check("t1_early", DW'(mem_rsp_valid), DW'(1'b0));
    @(negedge clk);
    chk_rsp("t1", 8'h22, {DS{8'hA5}});
    @(negedge clk);
    check("t1_single", DW'(mem_rsp_valid), DW'(1'b0));

    // Partial byte enable
    wr(8'h03, '0, '1);
    wr(8'h03, {DS{8'hFF}}, DS'(1));
    rd(8'h03, 8'h33);
    @(negedge clk);
    chk_rsp("t2", 8'h33, DW'(8'hFF));
    @(negedge clk);

    for (int k = 0; k < 16; k++) wr(AW'(8'h40 + k), pat(8'(k)), '1);

    // Backpressure fill, drain in order, credit re-enable
    mem_rsp_ready = 1'b0;
    for (int k = 1; k <= 4; k++) rd(AW'(8'h40 + k), TW'(k));
    set_rd(8'h45, 8'd5);
    check("t3_full", DW'(mem_req_ready), DW'(1'b0));
    @(negedge clk);
    check("t3_full_hold", DW'(mem_req_ready), DW'(1'b0));
    check("t3_head_hold", DW'(mem_rsp_tag), DW'(8'd1));
    @(negedge clk);
    check("t3_full_hold2", DW'(mem_req_ready), DW'(1'b0));
    chk_rsp("t3_r1", 8'd1, pat(8'd1));
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_reenable", DW'(mem_req_ready), DW'(1'b1));
    chk_rsp("t3_r2", 8'd2, pat(8'd2));
    @(negedge clk);
    set_rd(8'h46, 8'd6);
    check("t3_ready6", DW'(mem_req_ready), DW'(1'b1));
    chk_rsp("t3_r3", 8'd3, pat(8'd3));
    @(negedge clk);
    mem_req_valid = 1'b0;
    chk_rsp("t3_r4", 8'd4, pat(8'd4));
    @(negedge clk);
    chk_rsp("t3_r5", 8'd5, pat(8'd5));
    @(negedge clk);
    chk_rsp("t3_r6", 8'd6, pat(8'd6));
    @(negedge clk);
    check("t3_drained", DW'(mem_rsp_valid), DW'(1'b0));

    // Response fire while full with a read held: read goes in next cycle
    mem_rsp_ready = 1'b0;
    for (int k = 1; k <= 4; k++) rd(AW'(8'h40 + k), TW'(8'h20 + k));
    set_rd(8'h45, 8'h25);
    check("t4_full", DW'(mem_req_ready), DW'(1'b0));
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    mem_rsp_ready = 1'b0;
    check("t4_accept_next", DW'(mem_req_ready), DW'(1'b1));
    @(negedge clk);
    mem_req_valid = 1'b0;
    check("t4_pending_full", DW'(mem_req_ready), DW'(1'b0));
    mem_rsp_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk_rsp("t4", TW'(8'h20 + k), pat(8'(k)));
      @(negedge clk);
    end
    check("t4_drained", DW'(mem_rsp_valid), DW'(1'b0));

    // Throughput: 16 back-to-back reads
    for (int j = 0; j < 16 + L + 1; j++) begin
      if (j < 16) begin
        set_rd(AW'(8'h40 + j), TW'(j));
        check("t5_ready", DW'(mem_req_ready), DW'(1'b1));
      end else begin
        mem_req_valid = 1'b0;
      end
      if (j < L || j >= 16 + L) check("t5_idle", DW'(mem_rsp_valid), DW'(1'b0));
      else chk_rsp("t5", TW'(j - L), pat(8'(j - L)));
      @(negedge clk);
    end
    mem_req_valid = 1'b0;

    // Reset with reads outstanding
    wr(8'h77, pat(8'h77), '1);
    mem_rsp_ready = 1'b0;
    for (int k = 1; k <= 3; k++) rd(AW'(8'h40 + k), TW'(8'h30 + k));
    reset = 1'b1;
    #1;
    check("t6_rst_ready", DW'(mem_req_ready), DW'(1'b0));
    check("t6_rst_valid", DW'(mem_rsp_valid), DW'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    mem_rsp_ready = 1'b1;
    #1;
    check("t6_ready_after", DW'(mem_req_ready), DW'(1'b1));
    for (int k = 0; k < 4; k++) begin
      check("t6_no_rsp", DW'(mem_rsp_valid), DW'(1'b0));
      @(negedge clk);
    end
    rd(8'h77, 8'h44);
    check("t6_early", DW'(mem_rsp_valid), DW'(1'b0));
    @(negedge clk);
    chk_rsp("t6_persist", 8'h44, pat(8'h77));
    @(negedge clk);
    check("t6_single", DW'(mem_rsp_valid), DW'(1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
